// File: rtl/vtreg_init.sv
// Wishbone register-init master: queues write/read commands in a small FIFO and
// issues them one at a time as classic Wishbone cycles, with a per-cycle ack timeout.
module vtreg_init #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  input  logic [1:0]  cmd_sel,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [1:0]  wb_sel_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        rsp_valid,
  output logic [15:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [15:0]   adr_q, adr_d;
  logic [15:0]   dat_q, dat_d;
  logic [1:0]    sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          push;
  logic          pop;

  assign cmd_in    = {cmd_we, cmd_adr, cmd_dat, cmd_sel};
  assign head      = mem_q[rd_ptr_q];
  assign cmd_ready = (count_q < DEPTH_C);
  assign push      = cmd_valid & cmd_ready;

  // NOTE: the FIFO storage has no reset; emptiness is tracked by count_q alone,
  // so clearing the array would only cost a reset net on every storage bit.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        // wb_ack_i is deliberately not looked at here.
        if (count_q != '0) begin
          pop     = 1'b1;
          we_d    = head.we;
          adr_d   = head.adr;
          dat_d   = head.dat;
          sel_d   = head.sel;
          cyc_d   = 1'b1;
          cnt_d   = 8'd1;
          state_d = BUS;
        end
      end

      BUS: begin
        // Ack is tested first so it wins over a coinciding timeout.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 16'h0000 : wb_dat_i;
          cnt_d       = 8'd0;
          state_d     = IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 16'h0000;
          cnt_d       = 8'd0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 16'h0000;
      dat_q       <= 16'h0000;
      sel_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (count_q != '0) || (state_q == BUS);

endmodule

// File: tb/tb_vtreg_init.sv
// Self-checking bench for vtreg_init: register-file slave with per-command ack
// latency, plus a command/response reference model built from queues.
module tb_vtreg_init;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [15:0] cmd_adr;
  logic [15:0] cmd_dat;
  logic [1:0]  cmd_sel;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic        rsp_valid;
  logic [15:0] rsp_dat;
  logic        rsp_err;
  logic        busy;

  vtreg_init #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // ack_at: BUS cycle number in which the slave acks (0 = never).
  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          ack_at;
    int          acc_edge;
  } tcmd_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int          edge_n = 0;
  always @(posedge wb_clk_i) edge_n <= edge_n + 1;

  tcmd_t       cmd_q[$];
  logic [16:0] rsp_q[$];
  logic [15:0] slave_regs [8];
  logic [15:0] model_regs [8];
  tcmd_t       cur;
  int          bus_n          = 0;
  int          prev_end       = 0;
  int          last_rise_edge = 0;
  int          last_rsp_edge  = 0;
  int          acc_last       = 0;
  logic [15:0] last_dat       = 16'h0000;
  logic        last_err       = 1'b0;

  int          exp_start;
  int          d_exp;
  logic        err_e;
  logic [15:0] dat_e;
  logic [2:0]  idx;
  logic [16:0] rsp_e;

  // Slave and monitor: drives ack/data away from the rising edge and checks
  // the bus and response streams against the command model.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus_n    = 0;
      wb_ack_i = 1'b0;
      wb_dat_i = 16'($urandom);
      last_dat = 16'h0000;
      last_err = 1'b0;
      prev_end = 0;
    end else begin
      check("stb_eq_cyc", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
      wb_ack_i = 1'b0;
      wb_dat_i = 16'($urandom);
      if (wb_cyc_o) begin
        if (bus_n == 0) begin
          if (cmd_q.size() == 0) begin
            check("unexpected_bus", 32'd1, 32'd0);
            cur = '{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o, sel: wb_sel_o,
                    ack_at: 1, acc_edge: 0};
          end else begin
            cur       = cmd_q.pop_front();
            exp_start = (prev_end + 1 > cur.acc_edge + 1) ? prev_end + 1 : cur.acc_edge + 1;
            check("start_edge", edge_n, exp_start);
          end
          last_rise_edge = edge_n;
        end
        bus_n++;
        check("bus_we", {31'd0, wb_we_o}, {31'd0, cur.we});
        check("bus_adr", {16'd0, wb_adr_o}, {16'd0, cur.adr});
        check("bus_dat", {16'd0, wb_dat_o}, {16'd0, cur.dat});
        check("bus_sel", {30'd0, wb_sel_o}, {30'd0, cur.sel});
        if (bus_n == TIMEOUT + 1) check("cyc_too_long", 32'd1, 32'd0);
        if (bus_n == cur.ack_at) begin
          wb_ack_i = 1'b1;
          idx      = wb_adr_o[3:1];
          if (wb_we_o) begin
            if (wb_sel_o[0]) slave_regs[idx][7:0]  = wb_dat_o[7:0];
            if (wb_sel_o[1]) slave_regs[idx][15:8] = wb_dat_o[15:8];
          end else begin
            wb_dat_i = slave_regs[idx];
          end
        end
      end else if (bus_n != 0) begin
        err_e = !(cur.ack_at >= 1 && cur.ack_at <= TIMEOUT);
        d_exp = err_e ? TIMEOUT : cur.ack_at;
        check("bus_len", bus_n, d_exp);
        check("rsp_at_end", {31'd0, rsp_valid}, 32'd1);
        idx   = cur.adr[3:1];
        dat_e = 16'h0000;
        if (!err_e) begin
          if (cur.we) begin
            if (cur.sel[0]) model_regs[idx][7:0]  = cur.dat[7:0];
            if (cur.sel[1]) model_regs[idx][15:8] = cur.dat[15:8];
          end else begin
            dat_e = model_regs[idx];
          end
        end
        rsp_q.push_back({err_e, dat_e});
        prev_end = edge_n;
        bus_n    = 0;
      end else begin
        wb_ack_i = 1'($urandom);
      end

      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("spurious_rsp", 32'd1, 32'd0);
        end else begin
          rsp_e = rsp_q.pop_front();
          check("rsp_err", {31'd0, rsp_err}, {31'd0, rsp_e[16]});
          check("rsp_dat", {16'd0, rsp_dat}, {16'd0, rsp_e[15:0]});
        end
        last_dat      = rsp_dat;
        last_err      = rsp_err;
        last_rsp_edge = edge_n;
      end else begin
        check("rsp_dat_hold", {16'd0, rsp_dat}, {16'd0, last_dat});
        check("rsp_err_hold", {31'd0, rsp_err}, {31'd0, last_err});
      end
    end
  end

  task automatic push_cmd(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input int ack_at);
    tcmd_t c;
    int    guard;
    guard = 0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    while (!cmd_ready && guard < 1000) begin
      @(negedge wb_clk_i);
      guard++;
    end
    if (!cmd_ready) begin
      check("push_wait", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      c        = '{we: we, adr: adr, dat: dat, sel: sel, ack_at: ack_at, acc_edge: edge_n + 1};
      acc_last = edge_n + 1;
      @(posedge wb_clk_i);
      cmd_q.push_back(c);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge wb_clk_i);
      #1;
      guard++;
    end while (!(cmd_q.size() == 0 && bus_n == 0 && !busy) && guard < 3000);
    if (guard >= 3000) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          f_acc;
  int          r;
  int          ack_sel;
  int          guard;
  logic [15:0] radr;

  initial begin
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 16'h0000;
    cmd_dat   = 16'h0000;
    cmd_sel   = 2'b00;
    wb_ack_i  = 1'b0;
    wb_dat_i  = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      slave_regs[i] = 16'h0000;
      model_regs[i] = 16'h0000;
    end

    // Reset values
    repeat (3) @(negedge wb_clk_i);
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, wb_we_o}, 32'd0);
    check("rst_adr", {16'd0, wb_adr_o}, 32'd0);
    check("rst_dat", {16'd0, wb_dat_o}, 32'd0);
    check("rst_sel", {30'd0, wb_sel_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", {16'd0, rsp_dat}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Single write, 2-cycle slave: cyc after n+1, rsp after n+3
    push_cmd(1'b1, 16'h0002, 16'h0C05, 2'b11, 2);
    f_acc = acc_last;
    wait_idle();
    check("wr_rise_edge", last_rise_edge, f_acc + 1);
    check("wr_rsp_edge", last_rsp_edge, f_acc + 3);
    check("wr_slave_reg", {16'd0, slave_regs[1]}, 32'h0C05);

    // Read back, then read a slave-preset value
    push_cmd(1'b0, 16'h0002, 16'h1234, 2'b11, 2);
    wait_idle();
    check("rd_back", {16'd0, rsp_dat}, 32'h0C05);
    slave_regs[1] = 16'h0409;
    model_regs[1] = 16'h0409;
    push_cmd(1'b0, 16'h0002, 16'h0000, 2'b11, 2);
    wait_idle();
    check("rd_dat", {16'd0, rsp_dat}, 32'h0409);

    // FIFO full behind a stalled bus cycle
    push_cmd(1'b1, 16'h0004, 16'hA001, 2'b01, 20);
    guard = 0;
    while (bus_n == 0 && guard < 20) begin
      @(negedge wb_clk_i);
      #1;
      guard++;
    end
    check("full_bus_started", {31'd0, wb_cyc_o}, 32'd1);
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 16'(i * 2), 16'hB000 + 16'(i), 2'b11, 3);
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    push_cmd(1'b0, 16'h0004, 16'h0000, 2'b11, 1);
    check("ready_after_pop", acc_last, last_rise_edge + 1);
    wait_idle();

    // Timeout followed by a queued command; then the ack/timeout boundary
    push_cmd(1'b1, 16'h0006, 16'hDEAD, 2'b11, 0);
    push_cmd(1'b0, 16'h0006, 16'h0000, 2'b11, 2);
    wait_idle();
    push_cmd(1'b1, 16'h0008, 16'h5A5A, 2'b10, TIMEOUT);
    push_cmd(1'b1, 16'h000A, 16'h6B6B, 2'b11, TIMEOUT + 1);
    push_cmd(1'b0, 16'h0008, 16'h0000, 2'b11, 1);
    wait_idle();

    // Reset on the 3rd BUS cycle with two commands queued
    push_cmd(1'b1, 16'h000C, 16'h1111, 2'b11, 30);
    push_cmd(1'b1, 16'h000E, 16'h2222, 2'b11, 2);
    push_cmd(1'b1, 16'h000E, 16'h3333, 2'b11, 2);
    guard = 0;
    while (bus_n != 3 && guard < 20) begin
      @(negedge wb_clk_i);
      #1;
      guard++;
    end
    check("rst_mid_bus3", bus_n, 3);
    #2 wb_rst_i = 1'b1;
    #1;
    check("rst_mid_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_mid_stb", {31'd0, wb_stb_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_q.delete();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      #1;
      check("no_reissue", {31'd0, wb_cyc_o}, 32'd0);
    end
    push_cmd(1'b0, 16'h000C, 16'h0000, 2'b11, 2);
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14)       ack_sel = int'($urandom_range(1, 5));
      else if (r == 14) ack_sel = 0;
      else if (r == 15) ack_sel = TIMEOUT;
      else if (r == 16) ack_sel = TIMEOUT + 1;
      else              ack_sel = int'($urandom_range(6, 12));
      radr = 16'($urandom);
      push_cmd(1'($urandom), radr, 16'($urandom), 2'($urandom), ack_sel);
      repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
      if ($urandom_range(0, 9) == 0) wait_idle();
    end
    wait_idle();

    check("rsp_q_empty", rsp_q.size(), 0);
    check("cmd_q_empty", cmd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
